// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: turns the periodic move tick into snake head steps.
// Buffers up to two direction keys, rejects reversals, computes the next
// head cell and handshakes it with the body/collision unit.
// Build option: define SNAKE_WRAP_EN to make the grid wrap at its edges;
// without it, a step that leaves the grid ends the game.
module snake_move_ctrl #(
    parameter int GRID_W = 40,
    parameter int GRID_H = 30,
    parameter int XW     = 6,
    parameter int YW     = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          move,
    input  logic          pause,
    input  logic          restart,
    input  logic          dir_valid,
    input  logic [1:0]    dir_in,
    output logic          step_req,
    output logic [XW-1:0] next_x,
    output logic [YW-1:0] next_y,
    input  logic          step_ack,
    input  logic          step_hit,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    dir,
    output logic          step_done,
    output logic          game_over,
    output logic          overrun
);

    typedef enum logic [1:0] {RUN, REQ, DEAD} state_t;

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_RST = XW'(GRID_W / 2);
    localparam logic [YW-1:0] Y_RST = YW'(GRID_H / 2);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [YW-1:0] Y_ONE = YW'(1);
    localparam logic [1:0]    DIR_RST = 2'd1;

`ifdef SNAKE_WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    state_t      state;
    logic        pending;
    logic [1:0]  step_dir;
    logic [1:0]  q0, q1;      // q0 is the oldest queued key
    logic [1:0]  q_cnt;

    logic        start_tick, start_pend, start, pop, restart_now, key_ok;
    logic [1:0]  step_d, cnt_after, ref_d;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic        leave;

    // A step starts from RUN on an unpaused tick or on a tick deferred from REQ.
    assign start_tick  = (state == RUN) && move && !pause;
    assign start_pend  = (state == RUN) && pending;
    assign start       = start_tick || start_pend;
    assign pop         = start && (q_cnt != 2'd0);
    assign step_d      = pop ? q0 : dir;
    assign cnt_after   = q_cnt - {1'b0, pop};
    assign restart_now = (state == DEAD) && restart;

    // Reference for reversal checks: newest entry left after any pop, else dir.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        ref_d = dir;
        if (cnt_after == 2'd1)
            ref_d = pop ? q1 : q0;
        else if (cnt_after == 2'd2)
            ref_d = q1;
    end

    assign key_ok = dir_valid && !restart_now && (cnt_after != 2'd2) &&
                    (dir_in != ref_d) && (dir_in != (ref_d ^ 2'd2));

    // Candidate head cell one step along step_d, flagging an off-grid move.
    always_comb begin
        cand_x = head_x;
        cand_y = head_y;
        leave  = 1'b0;
        case (step_d)
            2'd0: if (head_y == '0)    begin cand_y = Y_MAX; leave = !WRAP; end
                  else                       cand_y = head_y - Y_ONE;
            2'd1: if (head_x == X_MAX) begin cand_x = '0;    leave = !WRAP; end
                  else                       cand_x = head_x + X_ONE;
            2'd2: if (head_y == Y_MAX) begin cand_y = '0;    leave = !WRAP; end
                  else                       cand_y = head_y + Y_ONE;
            default: if (head_x == '0) begin cand_x = X_MAX; leave = !WRAP; end
                  else                       cand_x = head_x - X_ONE;
        endcase
    end

    // Two-entry direction queue: pop shifts q1 down, an accepted key fills the free slot.
    always_ff @(posedge clk or negedge clr) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees the pre-edge values of all others.
        if (!clr) begin
            q0    <= 2'd0;
            q1    <= 2'd0;
            q_cnt <= 2'd0;
        end else if (restart_now) begin
            q_cnt <= 2'd0;
        end else begin
            if (key_ok && cnt_after == 2'd0)
                q0 <= dir_in;
            else if (pop)
                q0 <= q1;
            if (key_ok && cnt_after == 2'd1)
                q1 <= dir_in;
            q_cnt <= cnt_after + {1'b0, key_ok};
        end
    end

    // Step sequencer: RUN launches a step, REQ holds it until ack, DEAD waits for restart.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= RUN;
            head_x    <= X_RST;
            head_y    <= Y_RST;
            dir       <= DIR_RST;
            step_dir  <= DIR_RST;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            step_req  <= 1'b0;
            next_x    <= '0;
            next_y    <= '0;
            step_done <= 1'b0;
            game_over <= 1'b0;
        end else begin
            step_done <= 1'b0;
            case (state)
                RUN: begin
                    if (start) begin
                        // A fresh tick arriving while a deferred one launches stays deferred.
                        pending <= start_tick && start_pend;
                        if (leave) begin
                            state     <= DEAD;
                            game_over <= 1'b1;
                            pending   <= 1'b0;
                        end else begin
                            state    <= REQ;
                            step_req <= 1'b1;
                            next_x   <= cand_x;
                            next_y   <= cand_y;
                            step_dir <= step_d;
                        end
                    end
                end
                REQ: begin
                    if (move) begin
                        if (pending)
                            overrun <= 1'b1;
                        pending <= 1'b1;
                    end
                    if (step_ack) begin
                        step_req <= 1'b0;
                        if (step_hit) begin
                            state     <= DEAD;
                            game_over <= 1'b1;
                            pending   <= 1'b0;
                        end else begin
                            state     <= RUN;
                            head_x    <= next_x;
                            head_y    <= next_y;
                            dir       <= step_dir;
                            step_done <= 1'b1;
                        end
                    end
                end
                DEAD: begin
                    if (restart) begin
                        state     <= RUN;
                        head_x    <= X_RST;
                        head_y    <= Y_RST;
                        dir       <= DIR_RST;
                        step_dir  <= DIR_RST;
                        pending   <= 1'b0;
                        next_x    <= '0;
                        next_y    <= '0;
                        game_over <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Self-checking bench for snake_move_ctrl (default 40x30 grid).
module tb_snake_move_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       move = 1'b0, pause = 1'b0, restart = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic       step_ack = 1'b0, step_hit = 1'b0;
    logic       step_req, step_done, game_over, overrun;
    logic [5:0] next_x, head_x;
    logic [4:0] next_y, head_y;
    logic [1:0] dir;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x;
        int y;
    } cell_t;
    cell_t exp_q[$];

    typedef struct {
        bit         kv;
        logic [1:0] key;
        int         ex;
        int         ey;
        int         ed;
    } vec_t;
    vec_t vecs[5];

    snake_move_ctrl dut (
        .clk(clk), .clr(clr), .move(move), .pause(pause), .restart(restart),
        .dir_valid(dir_valid), .dir_in(dir_in),
        .step_req(step_req), .next_x(next_x), .next_y(next_y),
        .step_ack(step_ack), .step_hit(step_hit),
        .head_x(head_x), .head_y(head_y), .dir(dir),
        .step_done(step_done), .game_over(game_over), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // All drive tasks start and end #1 after a rising edge.
    task automatic do_reset();
        clr = 1'b0;
        #2;
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        move = 1'b1;
        @(posedge clk); #1;
        move = 1'b0;
    endtask

    task automatic key(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_in    = d;
        @(posedge clk); #1;
        dir_valid = 1'b0;
    endtask

    task automatic ack(input logic hit);
        step_ack = 1'b1;
        step_hit = hit;
        @(posedge clk); #1;
        step_ack = 1'b0;
        step_hit = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic push(input int x, input int y);
        cell_t c;
        c.x = x;
        c.y = y;
        exp_q.push_back(c);
    endtask

    // Wait (bounded) for step_req, then compare the candidate with the scoreboard.
    task automatic wait_req(input string name);
        bit    seen = 0;
        cell_t c;
        for (int i = 0; i < 8; i++) begin
            if (step_req) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            check({name, "_req"}, 0, 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
        end else begin
            c = exp_q.pop_front();
            check({name, "_nx"}, int'(next_x), c.x);
            check({name, "_ny"}, int'(next_y), c.y);
        end
    endtask

    initial begin
        vecs[0] = '{kv: 1'b0, key: 2'd0, ex: 21, ey: 15, ed: 1};
        vecs[1] = '{kv: 1'b1, key: 2'd0, ex: 20, ey: 14, ed: 0};
        vecs[2] = '{kv: 1'b1, key: 2'd2, ex: 20, ey: 16, ed: 2};
        vecs[3] = '{kv: 1'b1, key: 2'd3, ex: 21, ey: 15, ed: 1};
        vecs[4] = '{kv: 1'b1, key: 2'd1, ex: 21, ey: 15, ed: 1};

        // Reset state
        do_reset();
        check("rst_hx", int'(head_x), 20);
        check("rst_hy", int'(head_y), 15);
        check("rst_dir", int'(dir), 1);
        check("rst_req", int'(step_req), 0);
        check("rst_done", int'(step_done), 0);
        check("rst_go", int'(game_over), 0);
        check("rst_ovr", int'(overrun), 0);

        // Single key then one step from reset
        for (int i = 0; i < 5; i++) begin
            do_reset();
            if (vecs[i].kv) key(vecs[i].key);
            push(vecs[i].ex, vecs[i].ey);
            tick();
            wait_req($sformatf("vec%0d", i));
            ack(1'b0);
            check($sformatf("vec%0d_hx", i), int'(head_x), vecs[i].ex);
            check($sformatf("vec%0d_hy", i), int'(head_y), vecs[i].ey);
            check($sformatf("vec%0d_dir", i), int'(dir), vecs[i].ed);
            check($sformatf("vec%0d_done", i), int'(step_done), 1);
            check($sformatf("vec%0d_req_lo", i), int'(step_req), 0);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_lo", i), int'(step_done), 0);
        end

        // Reversal rejected, then a valid key queued
        do_reset();
        key(2'd3);
        key(2'd0);
        push(20, 14);
        tick();
        wait_req("rev");
        ack(1'b0);
        check("rev_dir", int'(dir), 0);

        // Full queue drops the third key
        do_reset();
        key(2'd0);
        key(2'd3);
        key(2'd2);
        push(20, 14);
        tick();
        wait_req("full1");
        ack(1'b0);
        push(19, 14);
        tick();
        wait_req("full2");
        ack(1'b0);
        check("full2_dir", int'(dir), 3);
        push(18, 14);
        tick();
        wait_req("full3");
        ack(1'b0);
        check("full3_dir", int'(dir), 3);

        // Key coincident with a pop is checked against dir once the queue empties
        do_reset();
        key(2'd0);
        dir_valid = 1'b1;
        dir_in    = 2'd2;
        push(20, 14);
        tick();
        dir_valid = 1'b0;
        wait_req("simul1");
        ack(1'b0);
        push(20, 15);
        tick();
        wait_req("simul2");
        ack(1'b0);
        check("simul2_dir", int'(dir), 2);

        // Pause blocks ticks in RUN
        do_reset();
        pause = 1'b1;
        tick();
        check("pause_req", int'(step_req), 0);
        pause = 1'b0;

        // Two ticks during REQ: pending + overrun, re-request one cycle after ack
        do_reset();
        push(21, 15);
        tick();
        wait_req("ovr1");
        tick();
        tick();
        check("ovr_flag", int'(overrun), 1);
        check("ovr_req_held", int'(step_req), 1);
        check("ovr_nx_held", int'(next_x), 21);
        ack(1'b0);
        check("ovr_req_gap", int'(step_req), 0);
        check("ovr_done", int'(step_done), 1);
        check("ovr_hx", int'(head_x), 21);
        push(22, 15);
        @(posedge clk); #1;
        check("ovr_req_re", int'(step_req), 1);
        wait_req("ovr2");
        ack(1'b0);
        check("ovr_hx2", int'(head_x), 22);

        // Collision: DEAD ignores ticks/acks, restart restores all but overrun
        do_reset();
        push(21, 15);
        tick();
        wait_req("hit");
        tick();
        tick();
        ack(1'b1);
        check("hit_go", int'(game_over), 1);
        check("hit_req", int'(step_req), 0);
        check("hit_done", int'(step_done), 0);
        check("hit_hx", int'(head_x), 20);
        check("hit_dir", int'(dir), 1);
        tick();
        @(posedge clk); #1;
        check("dead_req", int'(step_req), 0);
        ack(1'b0);
        check("dead_hx", int'(head_x), 20);
        check("dead_go", int'(game_over), 1);
        key(2'd0);
        pulse_restart();
        check("rs_go", int'(game_over), 0);
        check("rs_ovr", int'(overrun), 1);
        check("rs_hx", int'(head_x), 20);
        check("rs_hy", int'(head_y), 15);
        check("rs_dir", int'(dir), 1);
        push(21, 15);
        tick();
        wait_req("rs_step");
        ack(1'b0);
        check("rs_step_dir", int'(dir), 1);

        // Walk to the right edge
        do_reset();
        for (int i = 0; i < 19; i++) begin
            push(21 + i, 15);
            tick();
            wait_req($sformatf("walk%0d", i));
            ack(1'b0);
        end
        check("edge_hx", int'(head_x), 39);
`ifdef SNAKE_WRAP_EN
        push(0, 15);
        tick();
        wait_req("wrap");
        ack(1'b0);
        check("wrap_hx", int'(head_x), 0);
        check("wrap_go", int'(game_over), 0);
`else
        tick();
        check("edge_req", int'(step_req), 0);
        check("edge_go", int'(game_over), 1);
        check("edge_hx_kept", int'(head_x), 39);
`endif

        // Async clear mid-handshake drops step_req without a clock edge
        do_reset();
        push(21, 15);
        tick();
        wait_req("clr");
        #2;
        clr = 1'b0;
        #1;
        check("clr_req", int'(step_req), 0);
        check("clr_hx", int'(head_x), 20);
        clr = 1'b1;
        @(posedge clk); #1;

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
